// File: rtl/dcache_mshr_bank_if.sv
// dcache_mshr_bank_if
//   Groups the dcache-facing, memory-facing and completion signals of one
//   MSHR bank. The bank itself connects through the slave modport. The cache,
//   the memory side and the LSQ connect through the master modport.
//
//   Cache side : alloc, alloc_addr -> wr_idx, full
//   Memory req : mem_req_valid/mem_req_ready, mem_req_addr, mem_req_idx
//   Memory resp: mem_resp_valid, mem_resp_idx, mem_resp_data (no ready)
//   Completion : fin, fin_idx, fill_addr, fill_data, occupancy
//
// Handshake: mem_req transfers on a cycle where mem_req_valid && mem_req_ready
// at the rising edge. Once valid is raised, valid, addr and idx stay stable
// until that transfer. mem_resp has no ready and is accepted whenever it is
// valid.
interface dcache_mshr_bank_if #(
    parameter int IDX_BITS       = 3,
    parameter int LINE_ADDR_BITS = 28,
    parameter int LINE_BITS      = 128
);
    logic                      alloc;
    logic [LINE_ADDR_BITS-1:0] alloc_addr;
    logic [IDX_BITS-1:0]       wr_idx;
    logic                      full;
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [LINE_ADDR_BITS-1:0] mem_req_addr;
    logic [IDX_BITS-1:0]       mem_req_idx;
    logic                      mem_resp_valid;
    logic [IDX_BITS-1:0]       mem_resp_idx;
    logic [LINE_BITS-1:0]      mem_resp_data;
    logic                      fin;
    logic [IDX_BITS-1:0]       fin_idx;
    logic [LINE_ADDR_BITS-1:0] fill_addr;
    logic [LINE_BITS-1:0]      fill_data;
    logic [IDX_BITS:0]         occupancy;

    modport slave (
        input  alloc, alloc_addr, mem_req_ready, mem_resp_valid, mem_resp_idx, mem_resp_data,
        output wr_idx, full, mem_req_valid, mem_req_addr, mem_req_idx,
               fin, fin_idx, fill_addr, fill_data, occupancy
    );

    modport master (
        output alloc, alloc_addr, mem_req_ready, mem_resp_valid, mem_resp_idx, mem_resp_data,
        input  wr_idx, full, mem_req_valid, mem_req_addr, mem_req_idx,
               fin, fin_idx, fill_addr, fill_data, occupancy
    );
endinterface

// File: rtl/dcache_mshr_bank.sv
// dcache_mshr_bank
//   MSHR bank for one dcache bank. It tracks outstanding line misses and
//   issues fill requests in allocation order through an index FIFO. It
//   accepts fill responses out of order and reports each completion to the
//   LSQ with a one-cycle fin pulse. The same pulse carries the line address
//   and data to the cache data array.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-low reset
//   bus  - dcache_mshr_bank_if.slave; see the interface file for the signal
//          list and the handshake rules.
//
// Configuration:
//   MSHR_MERGE_EN - when defined, a miss to a line already held by a non-IDLE
//   entry merges into that entry. When undefined, every accepted miss takes
//   a fresh entry and issues its own request.
//
// Each entry steps through IDLE -> PEND -> ISSUED -> DONE -> IDLE. The
// per-entry state array state_q is the debug view of these FSMs.
module dcache_mshr_bank #(
    parameter int ENTRIES        = 8,
    parameter int IDX_BITS       = 3,
    parameter int LINE_ADDR_BITS = 28,
    parameter int LINE_BITS      = 128
) (
    input logic               clk,
    input logic               rst,
    dcache_mshr_bank_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ISSUED, ST_DONE} entry_state_e;

    entry_state_e              state_q [ENTRIES];
    entry_state_e              state_d [ENTRIES];
    logic [LINE_ADDR_BITS-1:0] addr_q  [ENTRIES];
    logic [LINE_ADDR_BITS-1:0] addr_d  [ENTRIES];
    logic [IDX_BITS-1:0]       fifo_q  [ENTRIES];
    logic [IDX_BITS-1:0]       fifo_d  [ENTRIES];
    logic [IDX_BITS-1:0]       head_q, head_d, tail_q, tail_d;
    logic [IDX_BITS:0]         cnt_q, cnt_d;
    logic                      fin_q, fin_d;
    logic [IDX_BITS-1:0]       fin_idx_q, fin_idx_d;
    logic [LINE_ADDR_BITS-1:0] fill_addr_q, fill_addr_d;
    logic [LINE_BITS-1:0]      fill_data_q, fill_data_d;

    logic                      match_hit, free_hit, alloc_new, req_fire, resp_ok;
    logic [IDX_BITS-1:0]       match_idx, free_idx, req_idx;
    logic [IDX_BITS:0]         occ;

    // Lookup: the scan runs from high to low index so that the lowest free
    // entry wins. A DONE entry still counts as occupied, so it cannot be
    // reallocated in its fin cycle.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == ST_IDLE) begin
                free_hit = 1'b1;
                free_idx = IDX_BITS'(i);
            end
`ifdef MSHR_MERGE_EN
            if (state_q[i] != ST_IDLE && addr_q[i] == bus.alloc_addr) begin
                match_hit = 1'b1;
                match_idx = IDX_BITS'(i);
            end
`endif
        end
    end

    assign bus.wr_idx = match_hit ? match_idx : free_idx;
    assign bus.full   = !match_hit && !free_hit;
    assign alloc_new  = bus.alloc && !bus.full && !match_hit;

    assign req_idx    = fifo_q[head_q];
    req_fire_comb: assert property (@(posedge clk) disable iff (!rst) cnt_q <= (IDX_BITS+1)'(ENTRIES));
    assign req_fire   = bus.mem_req_valid && bus.mem_req_ready;
    assign resp_ok    = bus.mem_resp_valid && state_q[bus.mem_resp_idx] == ST_ISSUED;

    // Next-state logic. Each event touches an entry in a different state
    // (pop: PEND, response: ISSUED, alloc: IDLE, retire: DONE), so the
    // updates never collide on one entry.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        fifo_d      = fifo_q;
        head_d      = head_q;
        tail_d      = tail_q;
        fin_d       = 1'b0;
        fin_idx_d   = fin_idx_q;
        fill_addr_d = fill_addr_q;
        fill_data_d = fill_data_q;

        for (int i = 0; i < ENTRIES; i++) begin
            if (state_q[i] == ST_DONE) state_d[i] = ST_IDLE;
        end

        if (req_fire) begin
            state_d[req_idx] = ST_ISSUED;
            head_d           = head_q + 1'b1;
        end

        if (resp_ok) begin
            state_d[bus.mem_resp_idx] = ST_DONE;
            fin_d       = 1'b1;
            fin_idx_d   = bus.mem_resp_idx;
            fill_addr_d = addr_q[bus.mem_resp_idx];
            fill_data_d = bus.mem_resp_data;
        end

        if (alloc_new) begin
            state_d[bus.wr_idx] = ST_PEND;
            addr_d[bus.wr_idx]  = bus.alloc_addr;
            fifo_d[tail_q]      = bus.wr_idx;
            tail_d              = tail_q + 1'b1;
        end

        cnt_d = cnt_q + (IDX_BITS+1)'(alloc_new) - (IDX_BITS+1)'(req_fire);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= ST_IDLE;
                addr_q[i]  <= '0;
                fifo_q[i]  <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            fin_q       <= 1'b0;
            fin_idx_q   <= '0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            fifo_q      <= fifo_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            fin_q       <= fin_d;
            fin_idx_q   <= fin_idx_d;
            fill_addr_q <= fill_addr_d;
            fill_data_q <= fill_data_d;
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (state_q[i] != ST_IDLE) occ = occ + (IDX_BITS+1)'(1);
        end
    end

    // The request valid comes straight from the registered FIFO count.
    assign bus.mem_req_valid = (cnt_q != '0);
    assign bus.mem_req_addr  = addr_q[req_idx];
    assign bus.mem_req_idx   = req_idx;
    assign bus.fin           = fin_q;
    assign bus.fin_idx       = fin_idx_q;
    assign bus.fill_addr     = fill_addr_q;
    assign bus.fill_data     = fill_data_q;
    assign bus.occupancy     = occ;
endmodule

// File: tb/tb_dcache_mshr_bank.sv
module tb_dcache_mshr_bank;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    dcache_mshr_bank_if #(.IDX_BITS(3), .LINE_ADDR_BITS(28), .LINE_BITS(128)) bus ();

    dcache_mshr_bank #(.ENTRIES(8), .IDX_BITS(3), .LINE_ADDR_BITS(28), .LINE_BITS(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Lines held per entry, a list of entries waiting to be requested, and
    // the completion that is reported in the current cycle.
    logic [27:0]  m_addr [8];
    bit           m_occ [8];
    bit           m_issued [8];
    int           m_req_q [$];
    bit           m_fin;
    int           m_fin_idx;
    logic [27:0]  m_fill_addr;
    logic [127:0] m_fill_data;
    bit           m_live;

    initial m_live = 1'b0;

    function automatic void m_lookup(input logic [27:0] a, output bit hit, output int widx,
                                     output bit is_full);
        int first_free;
        first_free = -1;
        hit  = 1'b0;
        widx = 0;
`ifdef MSHR_MERGE_EN
        for (int i = 0; i < 8; i++) if (m_occ[i] && m_addr[i] == a) begin hit = 1'b1; widx = i; end
`endif
        for (int i = 0; i < 8; i++) if (!m_occ[i] && first_free < 0) first_free = i;
        if (!hit && first_free >= 0) widx = first_free;
        is_full = !hit && first_free < 0;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                m_occ[i] = 1'b0; m_issued[i] = 1'b0; m_addr[i] = '0;
            end
            m_req_q.delete();
            m_fin = 1'b0; m_fin_idx = 0; m_fill_addr = '0; m_fill_data = '0;
            m_live = 1'b1;
        end else if (m_live) begin
            bit hit;
            bit is_full;
            int w;
            int ri;
            bit prev_fin;
            int prev_idx;
            m_lookup(bus.alloc_addr, hit, w, is_full);
            prev_fin = m_fin;
            prev_idx = m_fin_idx;
            m_fin = 1'b0;
            ri = int'(bus.mem_resp_idx);
            if (bus.mem_resp_valid && m_occ[ri] && m_issued[ri]) begin
                m_issued[ri] = 1'b0;
                m_fin = 1'b1; m_fin_idx = ri;
                m_fill_addr = m_addr[ri]; m_fill_data = bus.mem_resp_data;
            end
            if (prev_fin) m_occ[prev_idx] = 1'b0;
            if (m_req_q.size() > 0 && bus.mem_req_ready) begin
                m_issued[m_req_q[0]] = 1'b1;
                void'(m_req_q.pop_front());
            end
            if (bus.alloc && !is_full && !hit) begin
                m_occ[w] = 1'b1; m_addr[w] = bus.alloc_addr; m_issued[w] = 1'b0;
                m_req_q.push_back(w);
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (m_live) begin
            bit hit;
            bit is_full;
            int w;
            int occ;
            m_lookup(bus.alloc_addr, hit, w, is_full);
            occ = 0;
            for (int i = 0; i < 8; i++) if (m_occ[i]) occ++;
            chk("m_wr_idx", 128'(bus.wr_idx), 128'(w));
            chk("m_full", 128'(bus.full), 128'(is_full));
            chk("m_req_valid", 128'(bus.mem_req_valid), 128'(m_req_q.size() > 0));
            if (m_req_q.size() > 0) begin
                chk("m_req_idx", 128'(bus.mem_req_idx), 128'(m_req_q[0]));
                chk("m_req_addr", 128'(bus.mem_req_addr), 128'(m_addr[m_req_q[0]]));
            end
            chk("m_fin", 128'(bus.fin), 128'(m_fin));
            if (m_fin) chk("m_fin_idx", 128'(bus.fin_idx), 128'(m_fin_idx));
            chk("m_fill_addr", 128'(bus.fill_addr), 128'(m_fill_addr));
            chk("m_fill_data", bus.fill_data, m_fill_data);
            chk("m_occupancy", 128'(bus.occupancy), 128'(occ));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic respond(input int idx, input logic [127:0] data);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_idx   = 3'(idx);
        bus.mem_resp_data  = data;
        at_neg();
        tick();
        bus.mem_resp_valid = 1'b0;
        at_neg();
        chk("resp_fin", 128'(bus.fin), 128'(1));
        chk("resp_fin_idx", 128'(bus.fin_idx), 128'(idx));
        chk("resp_fill_data", bus.fill_data, data);
        tick();
    endtask

    int order [8];

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b0;
        bus.alloc = 1'b0;
        bus.alloc_addr = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_idx = 3'd3;
        bus.mem_resp_data = '0;

        // 1. reset with a stray response present
        tick();
        tick();
        at_neg();
        chk("rst_fin", 128'(bus.fin), 128'(0));
        chk("rst_req_valid", 128'(bus.mem_req_valid), 128'(0));
        chk("rst_occ", 128'(bus.occupancy), 128'(0));
        chk("rst_full", 128'(bus.full), 128'(0));
        chk("rst_wr_idx", 128'(bus.wr_idx), 128'(0));
        chk("rst_fill_data", bus.fill_data, 128'(0));
        tick();
        rst = 1'b1;
        bus.mem_resp_valid = 1'b0;

        // 2. single miss, plus a new alloc during its fin cycle
        bus.alloc = 1'b1; bus.alloc_addr = 28'h0000100;
        at_neg();
        chk("single_wr_idx", 128'(bus.wr_idx), 128'(0));
        tick();
        bus.alloc = 1'b0; bus.mem_req_ready = 1'b1;
        at_neg();
        chk("single_req_valid", 128'(bus.mem_req_valid), 128'(1));
        chk("single_req_addr", 128'(bus.mem_req_addr), 128'(28'h100));
        chk("single_req_idx", 128'(bus.mem_req_idx), 128'(0));
        chk("single_occ", 128'(bus.occupancy), 128'(1));
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b1; bus.mem_resp_idx = 3'd0; bus.mem_resp_data = {16{8'hA5}};
        at_neg();
        chk("single_req_done", 128'(bus.mem_req_valid), 128'(0));
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.alloc = 1'b1; bus.alloc_addr = 28'h0000200;
        at_neg();
        chk("single_fin", 128'(bus.fin), 128'(1));
        chk("single_fin_idx", 128'(bus.fin_idx), 128'(0));
        chk("single_fill_addr", 128'(bus.fill_addr), 128'(28'h100));
        chk("single_fill_data", bus.fill_data, {16{8'hA5}});
        chk("done_cycle_wr_idx", 128'(bus.wr_idx), 128'(1));
        tick();
        bus.alloc = 1'b0; bus.mem_req_ready = 1'b1;
        at_neg();
        chk("swap_occ", 128'(bus.occupancy), 128'(1));
        chk("swap_fin_low", 128'(bus.fin), 128'(0));
        chk("swap_req_idx", 128'(bus.mem_req_idx), 128'(1));
        tick();
        bus.mem_req_ready = 1'b0;
        respond(1, {16{8'h5A}});
        at_neg();
        chk("single_occ_zero", 128'(bus.occupancy), 128'(0));
        tick();

        // 4. full
        for (int i = 0; i < 8; i++) begin
            bus.alloc = 1'b1; bus.alloc_addr = 28'h10 + 28'(i);
            at_neg();
            chk("full_fill_wr_idx", 128'(bus.wr_idx), 128'(i));
            tick();
        end
        bus.alloc_addr = 28'h20;
        at_neg();
        chk("full_flag", 128'(bus.full), 128'(1));
        chk("full_occ", 128'(bus.occupancy), 128'(8));
        tick();
        bus.alloc = 1'b0; bus.alloc_addr = 28'h13;
        at_neg();
        chk("full_ignored_occ", 128'(bus.occupancy), 128'(8));
`ifdef MSHR_MERGE_EN
        chk("full_match_full", 128'(bus.full), 128'(0));
        chk("full_match_wr_idx", 128'(bus.wr_idx), 128'(3));
`else
        chk("full_nomerge_full", 128'(bus.full), 128'(1));
        chk("full_nomerge_wr_idx", 128'(bus.wr_idx), 128'(0));
`endif
        tick();
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            at_neg();
            chk("drain_req_idx", 128'(bus.mem_req_idx), 128'(i));
            chk("drain_req_addr", 128'(bus.mem_req_addr), 128'(28'h10 + 28'(i)));
            tick();
        end
        bus.mem_req_ready = 1'b0;

        // 6. out-of-order responses, back to back
        order = '{2, 0, 1, 3, 4, 5, 6, 7};
        for (int k = 0; k < 8; k++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_idx = 3'(order[k]);
            bus.mem_resp_data = {16{8'(k + 1)}};
            at_neg();
            if (k > 0) begin
                chk("ooo_fin", 128'(bus.fin), 128'(1));
                chk("ooo_fin_idx", 128'(bus.fin_idx), 128'(order[k - 1]));
            end
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        at_neg();
        chk("ooo_last_fin_idx", 128'(bus.fin_idx), 128'(7));
        tick();
        at_neg();
        chk("ooo_occ_zero", 128'(bus.occupancy), 128'(0));
        tick();
        bus.mem_resp_valid = 1'b1; bus.mem_resp_idx = 3'd5;
        tick();
        bus.mem_resp_valid = 1'b0;
        at_neg();
        chk("bogus_idle_fin", 128'(bus.fin), 128'(0));
        tick();

        // 5. backpressure, with a response aimed at a PEND entry
        for (int i = 0; i < 3; i++) begin
            bus.alloc = 1'b1; bus.alloc_addr = 28'h40 + 28'(i);
            tick();
        end
        bus.alloc = 1'b0;
        bus.mem_resp_valid = 1'b1; bus.mem_resp_idx = 3'd1;
        for (int c = 0; c < 5; c++) begin
            at_neg();
            if (c == 1) chk("bogus_pend_fin", 128'(bus.fin), 128'(0));
            chk("bp_req_valid", 128'(bus.mem_req_valid), 128'(1));
            chk("bp_req_idx", 128'(bus.mem_req_idx), 128'(0));
            chk("bp_req_addr", 128'(bus.mem_req_addr), 128'(28'h40));
            tick();
            bus.mem_resp_valid = 1'b0;
        end
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("bp_issue_idx", 128'(bus.mem_req_idx), 128'(i));
            tick();
        end
        bus.mem_req_ready = 1'b0;
        at_neg();
        chk("bp_req_empty", 128'(bus.mem_req_valid), 128'(0));
        tick();
        respond(2, {4{32'hDEADBEEF}});
        respond(1, {4{32'h01234567}});
        respond(0, {4{32'h89ABCDEF}});
        tick();

`ifdef MSHR_MERGE_EN
        // 3. merge, including a merge during the DONE cycle
        bus.alloc = 1'b1; bus.alloc_addr = 28'h100;
        at_neg();
        chk("merge_wr_idx0", 128'(bus.wr_idx), 128'(0));
        tick();
        at_neg();
        chk("merge_wr_idx1", 128'(bus.wr_idx), 128'(0));
        tick();
        bus.alloc = 1'b0; bus.mem_req_ready = 1'b1;
        at_neg();
        chk("merge_occ", 128'(bus.occupancy), 128'(1));
        tick();
        bus.mem_req_ready = 1'b0;
        at_neg();
        chk("merge_one_req", 128'(bus.mem_req_valid), 128'(0));
        bus.mem_resp_valid = 1'b1; bus.mem_resp_idx = 3'd0; bus.mem_resp_data = {16{8'h3C}};
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.alloc = 1'b1; bus.alloc_addr = 28'h100;
        at_neg();
        chk("merge_done_fin", 128'(bus.fin), 128'(1));
        chk("merge_done_wr_idx", 128'(bus.wr_idx), 128'(0));
        tick();
        bus.alloc = 1'b0;
        at_neg();
        chk("merge_done_occ", 128'(bus.occupancy), 128'(0));
        chk("merge_done_noreq", 128'(bus.mem_req_valid), 128'(0));
        tick();
`else
        // 6b. duplicate lines take separate entries
        bus.alloc = 1'b1; bus.alloc_addr = 28'h100;
        at_neg();
        chk("dup_wr_idx0", 128'(bus.wr_idx), 128'(0));
        tick();
        at_neg();
        chk("dup_wr_idx1", 128'(bus.wr_idx), 128'(1));
        tick();
        bus.alloc = 1'b0; bus.mem_req_ready = 1'b1;
        at_neg();
        chk("dup_occ", 128'(bus.occupancy), 128'(2));
        chk("dup_req0", 128'(bus.mem_req_idx), 128'(0));
        tick();
        at_neg();
        chk("dup_req1", 128'(bus.mem_req_idx), 128'(1));
        chk("dup_req1_addr", 128'(bus.mem_req_addr), 128'(28'h100));
        tick();
        bus.mem_req_ready = 1'b0;
        respond(0, {16{8'h11}});
        respond(1, {16{8'h22}});
        tick();
`endif

        // reset mid-operation drops an ISSUED entry
        bus.alloc = 1'b1; bus.alloc_addr = 28'h50;
        tick();
        bus.alloc = 1'b0; bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0; rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.mem_resp_valid = 1'b1; bus.mem_resp_idx = 3'd0;
        at_neg();
        chk("midrst_occ", 128'(bus.occupancy), 128'(0));
        chk("midrst_req_valid", 128'(bus.mem_req_valid), 128'(0));
        tick();
        bus.mem_resp_valid = 1'b0;
        at_neg();
        chk("midrst_resp_dropped", 128'(bus.fin), 128'(0));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_mshr_bank.md
Name: dcache_mshr_bank

Overview:
- Miss Status Holding Register bank; one instance per dcache bank (even/odd).
- Tracks outstanding line misses, issues fill requests to memory in allocation order, and accepts out-of-order fill responses.
- Drives the completion interface consumed by the load/store queue: next-allocation index, finish pulse and finish index.
- Hands fill data to the cache data array.

Parameters:
ENTRIES, 8, number of MSHR entries
IDX_BITS, 3, entry index width (log2 ENTRIES)
LINE_ADDR_BITS, 28, line address width (32-bit address, 16-byte lines)
LINE_BITS, 128, fill data width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
alloc  in  1  cache miss this cycle; allocate or merge
alloc_addr  in  LINE_ADDR_BITS  line address of miss; also continuous lookup key
wr_idx  out  IDX_BITS  combinational: entry a miss on alloc_addr uses this cycle
full  out  1  combinational: alloc on alloc_addr cannot be accepted
mem_req_valid  out  1  fill request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  LINE_ADDR_BITS  requested line
mem_req_idx  out  IDX_BITS  tag returned with response
mem_resp_valid  in  1  fill response (always accepted, no ready)
mem_resp_idx  in  IDX_BITS  entry being filled
mem_resp_data  in  LINE_BITS  line data
fin  out  1  one-cycle pulse: entry fin_idx completed
fin_idx  out  IDX_BITS  completing entry
fill_addr  out  LINE_ADDR_BITS  line written this fin cycle
fill_data  out  LINE_BITS  data written this fin cycle
occupancy  out  IDX_BITS+1  count of non-IDLE entries

Behaviour:
- Reset (rst==0 at a clk edge) forces:
  - all entries IDLE and issue FIFO empty;
  - fin=0, mem_req_valid=0, occupancy=0, wr_idx=0, full=0;
  - fill_addr=0, fill_data=0, fin_idx=0.
- Reset mid-operation drops all outstanding misses. Responses arriving after reset target IDLE entries and are ignored.
- Per-entry state:
  - IDLE -> PEND on allocation.
  - PEND -> ISSUED on mem_req handshake.
  - ISSUED -> DONE on mem_resp_valid with a matching idx (registered).
  - DONE -> IDLE after exactly one cycle.
- Match: a non-IDLE entry (PEND/ISSUED/DONE) whose address equals alloc_addr. At most one match exists.
- wr_idx:
  - If a match exists, wr_idx = matched index.
  - Otherwise, wr_idx = lowest-index IDLE entry.
  - Otherwise, wr_idx = 0.
- full = no match AND no IDLE entry. alloc while full is ignored; the cache stalls.
- alloc with a match is a merge: no state change, no request issued.
- alloc without a match:
  - the wr_idx entry takes alloc_addr and becomes PEND;
  - its index is pushed into the issue FIFO (depth ENTRIES).
- Issue:
  - mem_req_valid = FIFO non-empty, registered. The earliest request is the cycle after allocation.
  - mem_req_addr and mem_req_idx come from the FIFO head.
  - valid, addr and idx hold stable until the valid&ready handshake pops the FIFO.
  - A simultaneous push and pop is legal.
- Response:
  - Accepted at edge t only if the entry is ISSUED.
  - In cycle t+1: fin=1, fin_idx = entry, fill_addr = entry address, fill_data = captured data.
  - A response to a non-ISSUED entry is dropped, with no fin.
  - One response per cycle maximum; fin never overlaps for two entries.
- During the DONE cycle the entry still matches, so a miss on the same line merges with wr_idx==fin_idx, which the LSQ treats as complete. The entry is not reallocatable until the following cycle, so fin_idx never equals a freshly allocated wr_idx.
- occupancy updates on the edge after alloc (new entry) and after DONE->IDLE.
- A simultaneous new allocation and DONE->IDLE on different entries leaves occupancy unchanged.

Optional Feature:
MSHR_MERGE_EN:
- Defined: merge behaviour as above.
- Undefined:
  - match logic is removed; every alloc takes a new IDLE entry and issues its own request;
  - duplicate requests for one line are permitted;
  - full = no IDLE entry;
  - wr_idx = lowest IDLE entry.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with mem_resp_valid=1, idx 3 -> fin=0, mem_req_valid=0, occupancy=0, full=0, wr_idx=0.
2. Single miss: alloc 0x0000100 -> wr_idx=0; next cycle mem_req_valid=1, addr 0x0000100, idx 0. Ready, then resp idx 0 with data 0xA5..A5 -> fin=1, fin_idx=0, fill_data=0xA5..A5 one cycle later; occupancy 1->0 the cycle after.
3. Merge (MERGE_EN): alloc 0x100, then alloc 0x100 -> both wr_idx=0, exactly one request, occupancy=1. During entry 0's DONE cycle, alloc 0x100 -> wr_idx=0 with fin=1, fin_idx=0.
4. Full: 8 distinct allocs 0x10..0x17 -> full=1. alloc 0x20 is ignored (occupancy stays 8). alloc_addr=0x13 -> full=0, wr_idx=3.
5. Backpressure: alloc 0x40, 0x41, 0x42 with mem_req_ready=0 for 5 cycles -> req held at idx 0/0x40. Then ready=1 -> idx 0,1,2 issued on consecutive cycles.
6. Out-of-order/bogus response: responses idx 2 then idx 0 -> fin_idx 2 then 0. Response idx 5 for an IDLE entry -> no fin. Without MSHR_MERGE_EN, two allocs 0x100 -> wr_idx 0 then 1 and two requests.
